// File: rtl/game_round_controller_pkg.sv
// Shared types and constants for the two-player Morse game: controller states,
// Morse symbols, player2 segment results and round outcome codes.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_ENTRY,
    S_ARM,
    S_WAIT_READ,
    S_GUESS,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [1:0] MORSE_NONE = 2'b00;
  localparam logic [1:0] MORSE_DOT  = 2'b01;
  localparam logic [1:0] MORSE_LINE = 2'b11;

  typedef enum logic [1:0] {
    P2_NEUTRAL   = 2'b00,
    P2_CORRECT   = 2'b01,
    P2_INCORRECT = 2'b10
  } p2_result_t;

  typedef enum logic [1:0] {
    RR_NONE   = 2'b00,
    RR_P2_WIN = 2'b01,
    RR_P1_WIN = 2'b10
  } round_result_t;

  // Cycles WAIT_READ waits for player2's read flag before re-arming.
  localparam int unsigned WAIT_READ_CYCLES = 4;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// Bundle of the player1/player2 signals around the round controller.
// The controller attaches as slave; the surrounding game logic is the master.
interface game_round_controller_if;
  logic       start;
  logic       p1_done;
  logic [9:0] p1_value;
  logic       p2_read;
  logic [1:0] p2_correct;
  logic [9:0] p2_q;

  logic [9:0] code_out;
  logic       p2_next_input;
  logic       p1_enable;
  logic       p2_enable;
  logic [1:0] attempts_left;
  logic [1:0] round;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] round_result;
  logic       game_over;

  modport master (
    output start, p1_done, p1_value, p2_read, p2_correct, p2_q,
    input  code_out, p2_next_input, p1_enable, p2_enable, attempts_left,
           round, p1_score, p2_score, round_result, game_over
  );

  modport slave (
    input  start, p1_done, p1_value, p2_read, p2_correct, p2_q,
    output code_out, p2_next_input, p1_enable, p2_enable, attempts_left,
           round, p1_score, p2_score, round_result, game_over
  );
endinterface

// File: rtl/game_round_controller_round_timer.sv
// Per-round guess timer: loads TIMEOUT_CYCLES-1 on clear, counts down while run
// is high and flags expiry in the cycle the count sits at zero.
module round_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the two-player Morse game: latches player1's code, arms
// player2, supervises the guess (attempts, time limit, crack) and keeps scores.
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned NUM_ROUNDS     = 3
) (
  input logic                    clock,
  input logic                    reset,
  game_round_controller_if.slave bus
);

  state_t        state_q, state_d;
  logic [9:0]    code_q, code_d;
  logic [1:0]    attempts_q, attempts_d;
  logic [1:0]    round_q, round_d;
  logic [3:0]    p1_score_q, p1_score_d;
  logic [3:0]    p2_score_q, p2_score_d;
  round_result_t result_q, result_d;
  logic          accepted_q, accepted_d;
  logic [1:0]    wait_q, wait_d;
  logic          arm_q, p1_en_q, p2_en_q, over_q;

  logic timer_clear, timer_run, timer_expired;
  logic win, incorrect;

  assign timer_run   = (state_q == S_GUESS);
  assign timer_clear = (state_q != S_GUESS);

  round_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  assign win       = accepted_q && (bus.p2_q == code_q);
  assign incorrect = (bus.p2_correct == P2_INCORRECT);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    attempts_d = attempts_q;
    round_d    = round_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    result_d   = result_q;
    accepted_d = accepted_q;
    wait_d     = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_P1_ENTRY;
          round_d    = '0;
          p1_score_d = '0;
          p2_score_d = '0;
        end
      end
      S_P1_ENTRY: begin
        if (bus.p1_done && (bus.p1_value != '0)) begin
          code_d  = bus.p1_value;
          state_d = S_ARM;
        end
      end
      S_ARM: state_d = S_WAIT_READ;
      S_WAIT_READ: begin
        if (bus.p2_read) begin
          state_d = S_GUESS;
        end else if (wait_q == 2'(WAIT_READ_CYCLES - 1)) begin
          state_d = S_ARM;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_GUESS: begin
        if (bus.p2_correct == P2_CORRECT) accepted_d = 1'b1;
        // Scores and round advance on the decision edge so they are already
        // visible while RESULT is held.
        if (win) begin
          result_d   = RR_P2_WIN;
          state_d    = S_RESULT;
          p2_score_d = sat_inc4(p2_score_q);
          round_d    = round_q + 2'd1;
        end else if (timer_expired || (incorrect && attempts_q == 2'd1)) begin
          result_d   = RR_P1_WIN;
          state_d    = S_RESULT;
          p1_score_d = sat_inc4(p1_score_q);
          round_d    = round_q + 2'd1;
          if (!timer_expired) attempts_d = attempts_q - 2'd1;
        end else if (incorrect) begin
          attempts_d = attempts_q - 2'd1;
        end
      end
      S_RESULT: begin
        state_d = (round_q == 2'(NUM_ROUNDS)) ? S_DONE : S_P1_ENTRY;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_P1_ENTRY) && (state_q != S_P1_ENTRY)) begin
      attempts_d = 2'(MAX_ATTEMPTS);
      accepted_d = 1'b0;
      result_d   = RR_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      attempts_q <= 2'(MAX_ATTEMPTS);
      round_q    <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      result_q   <= RR_NONE;
      accepted_q <= 1'b0;
      wait_q     <= '0;
      arm_q      <= 1'b0;
      p1_en_q    <= 1'b0;
      p2_en_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      attempts_q <= attempts_d;
      round_q    <= round_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      result_q   <= result_d;
      accepted_q <= accepted_d;
      wait_q     <= wait_d;
      arm_q      <= (state_d == S_ARM);
      p1_en_q    <= (state_d == S_P1_ENTRY);
      p2_en_q    <= (state_d == S_GUESS);
      over_q     <= (state_d == S_DONE);
    end
  end

  assign bus.code_out      = code_q;
  assign bus.p2_next_input = arm_q;
  assign bus.p1_enable     = p1_en_q;
  assign bus.p2_enable     = p2_en_q;
  assign bus.attempts_left = attempts_q;
  assign bus.round         = round_q;
  assign bus.p1_score      = p1_score_q;
  assign bus.p2_score      = p2_score_q;
  assign bus.round_result  = result_q;
  assign bus.game_over     = over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed/randomized bench for game_round_controller with a score/round model
// derived from the game rules (short timeout so the time limit is reachable).
module tb_game_round_controller;

  localparam int unsigned T   = 16;
  localparam int unsigned MAX = 3;
  localparam int unsigned NR  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  game_round_controller_if bus_if ();

  game_round_controller #(
    .MAX_ATTEMPTS   (MAX),
    .TIMEOUT_CYCLES (T),
    .NUM_ROUNDS     (NR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_p1, exp_p2, exp_round;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [9:0] other(input logic [9:0] c);
    logic [9:0] v;
    do v = 10'($urandom); while (v == c);
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_code"},  32'(bus_if.code_out), 0);
    check({tag, "_arm"},   32'(bus_if.p2_next_input), 0);
    check({tag, "_p1en"},  32'(bus_if.p1_enable), 0);
    check({tag, "_p2en"},  32'(bus_if.p2_enable), 0);
    check({tag, "_att"},   32'(bus_if.attempts_left), MAX);
    check({tag, "_round"}, 32'(bus_if.round), 0);
    check({tag, "_p1sc"},  32'(bus_if.p1_score), 0);
    check({tag, "_p2sc"},  32'(bus_if.p2_score), 0);
    check({tag, "_res"},   32'(bus_if.round_result), 0);
    check({tag, "_over"},  32'(bus_if.game_over), 0);
  endtask

  task automatic new_game_check(input string tag);
    exp_p1 = 0; exp_p2 = 0; exp_round = 0;
    check({tag, "_p1en"},  32'(bus_if.p1_enable), 1);
    check({tag, "_over"},  32'(bus_if.game_over), 0);
    check({tag, "_p1sc"},  32'(bus_if.p1_score), 0);
    check({tag, "_p2sc"},  32'(bus_if.p2_score), 0);
    check({tag, "_round"}, 32'(bus_if.round), 0);
    check({tag, "_res"},   32'(bus_if.round_result), 0);
  endtask

  // From P1_ENTRY: enter code, observe the arm pulse, answer read, land in GUESS.
  task automatic arm(input logic [9:0] code, input bit rearm);
    bus_if.p1_done = 1'b1; bus_if.p1_value = code;
    tick();
    bus_if.p1_done = 1'b0; bus_if.p1_value = 10'($urandom);
    check("arm_pulse", 32'(bus_if.p2_next_input), 1);
    check("code_latch", 32'(bus_if.code_out), 32'(code));
    check("p1en_off", 32'(bus_if.p1_enable), 0);
    tick();
    check("arm_one_cycle", 32'(bus_if.p2_next_input), 0);
    if (rearm) begin
      repeat (3) tick();
      check("no_early_rearm", 32'(bus_if.p2_next_input), 0);
      tick();
      check("rearm_pulse", 32'(bus_if.p2_next_input), 1);
      check("code_stable", 32'(bus_if.code_out), 32'(code));
      tick();
    end
    bus_if.p2_read = 1'b1;
    tick();
    bus_if.p2_read = 1'b0;
    check("guess_entry", 32'(bus_if.p2_enable), 1);
    check("attempts_full", 32'(bus_if.attempts_left), MAX);
  endtask

  // Called in the RESULT cycle; applies the outcome to the model and checks.
  task automatic finish_round(input bit p2_wins);
    if (p2_wins) exp_p2 = sat15(exp_p2 + 1);
    else         exp_p1 = sat15(exp_p1 + 1);
    exp_round++;
    check("result_code", 32'(bus_if.round_result), p2_wins ? 1 : 2);
    check("p1_score", 32'(bus_if.p1_score), 32'(exp_p1));
    check("p2_score", 32'(bus_if.p2_score), 32'(exp_p2));
    check("round", 32'(bus_if.round), 32'(exp_round));
    check("result_p2en", 32'(bus_if.p2_enable), 0);
    tick();
    if (exp_round == NR) begin
      check("game_over", 32'(bus_if.game_over), 1);
      check("result_held", 32'(bus_if.round_result), p2_wins ? 1 : 2);
    end else begin
      check("next_p1en", 32'(bus_if.p1_enable), 1);
      check("result_clr", 32'(bus_if.round_result), 0);
      check("att_reload", 32'(bus_if.attempts_left), MAX);
    end
  endtask

  // kind: 0 win, 1 three incorrect, 2 timeout, 3 win with simultaneous incorrect
  task automatic play(input int kind, input logic [9:0] code, input bit rearm);
    arm(code, rearm);
    case (kind)
      0: begin
        bus_if.p2_q = code; bus_if.p2_correct = 2'b01;
        tick();
        bus_if.p2_correct = 2'b00;
        check("no_win_unaccepted", 32'(bus_if.p2_enable), 1);
        tick();
        finish_round(1'b1);
      end
      1: begin
        bus_if.p2_q = other(code);
        for (int i = 0; i < 3; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          bus_if.p2_correct = 2'b10;
          tick();
          bus_if.p2_correct = 2'b00;
          if (i < 2) check("attempts_step", 32'(bus_if.attempts_left), 32'(2 - i));
        end
        check("attempts_zero", 32'(bus_if.attempts_left), 0);
        finish_round(1'b0);
      end
      2: begin
        bus_if.p2_q = 10'd0;
        repeat (T - 1) tick();
        check("no_early_timeout", 32'(bus_if.p2_enable), 1);
        tick();
        finish_round(1'b0);
      end
      default: begin
        bus_if.p2_q = other(code); bus_if.p2_correct = 2'b01;
        tick();
        bus_if.p2_correct = 2'b10;
        tick();
        check("att_two", 32'(bus_if.attempts_left), 2);
        tick();
        check("att_one", 32'(bus_if.attempts_left), 1);
        bus_if.p2_q = code;
        tick();
        bus_if.p2_correct = 2'b00;
        finish_round(1'b1);
      end
    endcase
    bus_if.p2_correct = 2'b00;
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.p1_done = 1'b0; bus_if.p1_value = '0;
    bus_if.p2_read = 1'b0; bus_if.p2_correct = 2'b00; bus_if.p2_q = '0;
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check("idle_p1en", 32'(bus_if.p1_enable), 0);

    // Game 1: win, attempts exhausted, timeout.
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    new_game_check("g1_start");
    bus_if.p1_done = 1'b1; bus_if.p1_value = '0;
    tick();
    bus_if.p1_done = 1'b0;
    check("zero_code_p1en", 32'(bus_if.p1_enable), 1);
    check("zero_code_arm", 32'(bus_if.p2_next_input), 0);
    check("zero_code_latch", 32'(bus_if.code_out), 0);
    play(0, 10'b0101110000, 1'b0);
    play(1, 10'($urandom_range(1, 1023)), 1'b0);
    play(2, 10'($urandom_range(1, 1023)), 1'b0);

    // start held in DONE restarts; start elsewhere is ignored.
    bus_if.start = 1'b1;
    tick();
    new_game_check("g2_start");
    play(3, 10'($urandom_range(1, 1023)), 1'b1);
    bus_if.start = 1'b0;
    play(int'($urandom_range(0, 3)), 10'($urandom_range(1, 1023)), 1'b0);
    play(int'($urandom_range(0, 3)), 10'($urandom_range(1, 1023)), 1'b0);
    repeat (2) tick();
    check("done_hold_over", 32'(bus_if.game_over), 1);
    check("done_hold_p1", 32'(bus_if.p1_score), 32'(exp_p1));
    check("done_hold_p2", 32'(bus_if.p2_score), 32'(exp_p2));

    // Game 3: reset in the middle of a guess.
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    new_game_check("g3_start");
    arm(10'($urandom_range(1, 1023)), 1'b0);
    bus_if.p2_q = '0; bus_if.p2_correct = 2'b10;
    tick();
    bus_if.p2_correct = 2'b00;
    check("g3_att", 32'(bus_if.attempts_left), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midreset");
    tick();
    check("post_reset_idle", 32'(bus_if.p1_enable), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Round sequencer for the two-player Morse game. It accepts player1's code and latches it. It arms the player2 guessing datapath with that code, then supervises the guess: it counts incorrect attempts, enforces a per-round time limit, detects a crack, and keeps scores over a fixed number of rounds. It sits between the player1 entry path and the player2 comparator and is the only block that drives player2's `next_input` and `p1_value`.

## Interface
- `MAX_ATTEMPTS`, 3: incorrect segments tolerated per round; the round is lost on reaching this count.
- `TIMEOUT_CYCLES`, 50_000_000: clock cycles allowed in GUESS per round.
- `NUM_ROUNDS`, 3: rounds per game.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level; a new game starts when it is sampled high in IDLE or DONE.
- `p1_done`  in  1  one-cycle pulse: player1 finished code entry.
- `p1_value`  in  10  player1 code, valid while `p1_done` is high.
- `p2_read`  in  1  player2 `read` flag.
- `p2_correct`  in  2  player2 per-segment result: 00 neutral, 01 correct, 10 incorrect.
- `p2_q`  in  10  player2 accumulated value.
- `code_out`  out  10  latched code, fed to player2 `p1_value`.
- `p2_next_input`  out  1  one-cycle arm pulse to player2.
- `p1_enable`, `p2_enable`  out  1 each  entry enables for the players' input decoders.
- `attempts_left`  out  2  equals MAX_ATTEMPTS minus the incorrect count.
- `round`  out  2  current round, 0-based.
- `p1_score`, `p2_score`  out  4 each  rounds won, saturating at 15.
- `round_result`  out  2  00 none, 01 player2 win, 10 player1 win; held until the next round starts.
- `game_over`  out  1  high in DONE.

## Operation
- States: IDLE, P1_ENTRY, ARM, WAIT_READ, GUESS, RESULT, DONE.
- IDLE → P1_ENTRY on `start`. On this transition, clear both scores and `round`.
- P1_ENTRY: `p1_enable`=1.
  - On `p1_done` with `p1_value`≠0: latch the value into `code_out` and go to ARM.
  - A `p1_done` with `p1_value`=0 is ignored; the state stays P1_ENTRY.
- ARM: `p2_next_input`=1 for exactly one cycle, then go to WAIT_READ.
- WAIT_READ:
  - Stay until `p2_read`=1 is sampled, then go to GUESS.
  - If `p2_read` is not seen within 4 cycles, return to ARM (re-arm).
- GUESS: `p2_enable`=1; the timer runs. Evaluation order, highest priority first:
  - (1) Win: `p2_q`==`code_out` and at least one correct dot/line accepted in this round → round_result=01.
  - (2) Timer reaches TIMEOUT_CYCLES-1 → round_result=10.
  - (3) `p2_correct`==10 → decrement `attempts_left`. If it was 1, round_result=10.
  - `p2_correct`==01 sets the accepted flag.
  - A win and an incorrect pulse in the same cycle resolve as a win.
- RESULT (1 cycle): increment the winner's score (saturating) and `round`. If `round`==NUM_ROUNDS-1, go to DONE; otherwise go to P1_ENTRY.
- DONE: `game_over`=1; scores are held. `start` → P1_ENTRY with scores and round cleared.
- Entry to P1_ENTRY from any state reloads `attempts_left`=MAX_ATTEMPTS, clears the timer and the accepted flag, and sets round_result=00.
- Both enables are low outside P1_ENTRY and GUESS.

## Timing
- Reset values: state IDLE, `code_out`=0, `p2_next_input`=0, enables 0, `attempts_left`=MAX_ATTEMPTS, `round`=0, scores 0, `round_result`=00, `game_over`=0.
- All outputs are registered.
- Reset mid-round: on the next edge, return to IDLE with reset values; scores are lost.
- Arm latency: `p1_done` at cycle n → ARM at n+1 → `p2_next_input` high during n+1.
  - Player2 `read` is high during n+2.
  - WAIT_READ samples it at the end of n+2, so GUESS holds at n+3.
  - Player2 reloads its copy from `code_out` on that same edge, so `code_out` stays stable from n+1 onward.
- Win is detected one cycle after the final `p2_correct`=01, because `p2_q` registers then.
- Scores update in the RESULT cycle, which is one cycle after the decision.
- Timer: the GUESS exit on timeout occurs exactly TIMEOUT_CYCLES cycles after GUESS entry.
- `start` held high in DONE restarts immediately. `start` in any other state is ignored.

## Structure
- Shared package `game_pkg`:
  - state encoding
  - MORSE_NONE/DOT/LINE (00/01/11)
  - player2 result codes (NEUTRAL/CORRECT/INCORRECT)
  - round_result codes
- Sub-module `round_timer`:
  - loadable down-counter with `clear` and `run` inputs and an `expired` pulse
  - width is $clog2(TIMEOUT_CYCLES)

## Test plan
- Reset, then `start`, then `p1_done` with `p1_value`=10'b0101110000 → `p2_next_input` pulses 1 cycle later; `code_out`=0x170; GUESS by cycle n+3.
- In GUESS, drive `p2_correct`=01 once and then `p2_q`=0x170 → RESULT next cycle; `p2_score`=1; `round_result`=01; `round`=1.
- Three `p2_correct`=10 pulses → `attempts_left` steps 2, 1, then RESULT; `p1_score`=1; `round_result`=10.
- TIMEOUT_CYCLES=16 with no player2 activity → RESULT exactly 16 cycles after GUESS entry; player1 wins.
- Win and incorrect in the same cycle → player2 win; three rounds played → `game_over`=1; `start` clears scores.
- `p1_done` with `p1_value`=0 → stays in P1_ENTRY. `reset` asserted in GUESS → all outputs return to reset values on the next edge.
